// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_rx_state_e : receiver FSM state encoding
//   clks_per_bit()  : system clocks per serial bit (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  function automatic int clks_per_bit(input int sys_freq, input int baud_rate);
    return sys_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset; both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output (two clocks of latency)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: both stages reset to the line's idle level so the receiver never
  // sees a phantom start edge while the chain refills after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing with DATA_SIZE data bits, LSB first.
// The line is sampled at mid-bit after a 2-FF synchroniser; completed words
// are held on dout under a recv_req/recv_ack handshake.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   rx        : asynchronous serial input, idle high
//   dout      : received word, valid while recv_req=1
//   recv_req  : word available, held until acknowledged
//   recv_ack  : consumer accepts dout
//   frame_err : 1-cycle pulse, stop bit sampled low
//   overrun   : 1-cycle pulse, new word replaced an unacknowledged one
//   busy      : receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 recv_req,
  input  logic                 recv_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_SIZE + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $fatal(1, "uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_rx_state_e       state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic [DATA_SIZE-1:0] shift_q,     shift_d;
  logic [DATA_SIZE-1:0] dout_q,      dout_d;
  logic                 recv_req_q,  recv_req_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 word_done;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    recv_req_d  = recv_req_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    word_done   = 1'b0;

    if (recv_req_q && recv_ack) begin
      recv_req_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line at the middle of the start bit; a glitch that
        // has already gone high is dropped silently.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the MSB leaves the word
          // in natural order after the last data bit.
          shift_d = {rx_s, shift_q[DATA_SIZE-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d   = IDLE;
            word_done = 1'b1;
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // A line held low must return high before another start is armed.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed word always loads; an ack in the same cycle retires the
    // old word cleanly, otherwise the unread word is lost and flagged.
    if (word_done) begin
      dout_d     = shift_q;
      recv_req_d = 1'b1;
      overrun_d  = recv_req_q && !recv_ack;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      recv_req_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      recv_req_q  <= recv_req_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dout      = dout_q;
  assign recv_req  = recv_req_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
